// File: rtl/countdown_display_pkg.sv
// ---------------------------------------------------------------------------
// countdown_display_pkg
// Shared definitions for the countdown seven-segment display:
//   - convState_t : states of the sequential binary-to-BCD converter
//   - SEG_0..SEG_9, SEG_BLANK : active-low cathode patterns, bit order gfedcba
//   - BCD_DIGIT_W, NUM_DIGITS, BCD_W, BIN_W : widths used by the converter
//   - MAX_DISPLAY : largest value the four digits can show
//   - segEncode() : digit to cathode pattern
//   - bcdAdjust() : the add-3 correction applied before every shift
// ---------------------------------------------------------------------------
package countdown_display_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = NUM_DIGITS * BCD_DIGIT_W;
  localparam int BIN_W       = 14;

  localparam logic [15:0] MAX_DISPLAY = 16'd9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } convState_t;

  // Cathodes are active-low, so a 0 bit lights that segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Maps one BCD digit to its cathode pattern; codes 10..15 never occur
  // after conversion, but they fall back to a dark digit to be safe.
  function automatic logic [6:0] segEncode(input logic [BCD_DIGIT_W-1:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // Double-dabble correction: any nibble of 5 or more gets 3 added so that
  // the following left shift carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] bcdAdjust(input logic [BCD_W-1:0] value);
    logic [BCD_W-1:0] result;
    result = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (result[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
        result[i*BCD_DIGIT_W +: BCD_DIGIT_W] = result[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/countdown_display_bcd.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-add-3 converter, one shift per clock.
// A conversion takes 16 SHIFT cycles followed by one LATCH cycle.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, aborts any conversion
//   start  : sampled in IDLE; captures bin and begins converting
//   bin    : binary value to convert (already limited to 0..9999)
//   busy   : high in SHIFT and LATCH
//   done   : high during the LATCH cycle, when bcd holds the final result
//   bcd    : four packed BCD digits, units in bcd[3:0]
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import countdown_display_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  convState_t       r_state;
  logic [BCD_W-1:0] r_binShift;
  logic [BCD_W-1:0] r_work;
  logic [3:0]       r_shiftCnt;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] w_adjusted;

  // Correction of the partially built BCD value ahead of this cycle's shift.
  assign w_adjusted = bcdAdjust(r_work);

  // Converter FSM. The binary operand is widened to 16 bits so that exactly
  // 16 shifts are performed; the extra leading zeros do not change the
  // result. busy and done are registered alongside the state so they line
  // up with SHIFT/LATCH exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_binShift <= '0;
      r_work     <= '0;
      r_shiftCnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_binShift <= {{(BCD_W-BIN_W){1'b0}}, bin};
            r_work     <= '0;
            r_shiftCnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_work     <= {w_adjusted[BCD_W-2:0], r_binShift[BCD_W-1]};
          r_binShift <= {r_binShift[BCD_W-2:0], 1'b0};
          if (r_shiftCnt == 4'(BCD_W - 1)) begin
            r_done  <= 1'b1;
            r_state <= LATCH;
          end else begin
            r_shiftCnt <= r_shiftCnt + 4'd1;
          end
        end
        LATCH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_work;

endmodule

// File: rtl/countdown_display.sv
// ---------------------------------------------------------------------------
// countdown_display
// Shows the game timer's seconds on a 4-digit multiplexed seven-segment
// display with leading-zero blanking, and blinks the whole display while
// the timer has expired.
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays lit
//   BLINK_DIV   : clock cycles per blink half-period while finished
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   count  : binary seconds remaining (saturated to 9999 for display)
//   finish : timer expired, enables blinking
//   an     : active-low one-hot digit anodes, an[0] = units
//   seg    : active-low cathodes, gfedcba (seg[0] = a)
//   dp     : decimal point, always off (1)
//   busy   : high while a BCD conversion is running
// ---------------------------------------------------------------------------
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        finish,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [15:0]            r_lastCount;
  logic [BCD_W-1:0]       r_digits;
  logic [SCAN_W-1:0]      r_scanCnt;
  logic [1:0]             r_scanIdx;
  logic [BLINK_W-1:0]     r_blinkCnt;
  logic                   r_blinkOn;
  logic [3:0]             r_an;
  logic [6:0]             r_seg;
  logic                   r_dp;

  logic [BIN_W-1:0]       w_satCount;
  logic                   w_start;
  logic                   w_busy;
  logic                   w_done;
  logic [BCD_W-1:0]       w_bcd;
  logic [BCD_DIGIT_W-1:0] w_digit;
  logic                   w_lit;

  // Anything above 9999 cannot be shown on four digits, so it is clamped
  // before it reaches the converter.
  assign w_satCount = (count > MAX_DISPLAY) ? MAX_DISPLAY[BIN_W-1:0] : count[BIN_W-1:0];

  // A new conversion is requested only when the converter is idle and the
  // timer value differs from the one last handed to it, so changes that
  // arrive mid-conversion are picked up on the next idle cycle.
  assign w_start = (count != r_lastCount) && !w_busy;

  bin_to_bcd_seq u_conv (
    .clock (clock),
    .reset (reset),
    .start (w_start),
    .bin   (w_satCount),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Remembers the raw timer value at each capture and loads the displayed
  // digits during the converter's LATCH cycle; a reset mid-conversion
  // leaves the digits cleared instead of holding partial results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lastCount <= '0;
      r_digits    <= '0;
    end else begin
      if (w_start) begin
        r_lastCount <= count;
      end
      if (w_done) begin
        r_digits <= w_bcd;
      end
    end
  end

  // Digit multiplexing: the active digit advances every REFRESH_DIV cycles
  // and the 2-bit index wraps from 3 back to 0 on its own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scanCnt <= '0;
      r_scanIdx <= '0;
    end else if (r_scanCnt == SCAN_W'(REFRESH_DIV - 1)) begin
      r_scanCnt <= '0;
      r_scanIdx <= r_scanIdx + 2'd1;
    end else begin
      r_scanCnt <= r_scanCnt + 1'b1;
    end
  end

  // Blink timing while finished. Dropping finish clears the counter and
  // forces the visible phase so the display comes straight back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blinkCnt <= '0;
      r_blinkOn  <= 1'b1;
    end else if (!finish) begin
      r_blinkCnt <= '0;
      r_blinkOn  <= 1'b1;
    end else if (r_blinkCnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blinkCnt <= '0;
      r_blinkOn  <= ~r_blinkOn;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  // Selects the digit under the scan index and decides whether it is
  // lit: units always, higher digits only if they or something above
  // them is nonzero.
  assign w_digit = r_digits[{r_scanIdx, 2'b00} +: BCD_DIGIT_W];

  always_comb begin
    w_lit = 1'b1;
    case (r_scanIdx)
      2'd0:    w_lit = 1'b1;
      2'd1:    w_lit = |r_digits[BCD_W-1:4];
      2'd2:    w_lit = |r_digits[BCD_W-1:8];
      2'd3:    w_lit = |r_digits[BCD_W-1:12];
      default: w_lit = 1'b1;
    endcase
  end

  // Registered pad drivers. Only the blink phase register is consulted
  // here (not finish directly) so a blink change shows up exactly one
  // cycle after the phase itself changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_dp <= 1'b1;
      if (!r_blinkOn || !w_lit) begin
        r_an  <= 4'b1111;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= ~(4'b0001 << r_scanIdx);
        r_seg <= segEncode(w_digit);
      end
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign busy = w_busy;

endmodule

// File: tb/tb_countdown_display.sv
// ---------------------------------------------------------------------------
// tb_countdown_display
// Self-checking bench for countdown_display with REFRESH_DIV=4, BLINK_DIV=16.
// Expected display images come from decimal arithmetic on the timer value.
// ---------------------------------------------------------------------------
module tb_countdown_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;
  localparam int BUSY_LIMIT  = 60;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] count;
  logic        finish;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Results of the most recent observation window.
  logic [27:0] obsImage;
  logic [3:0]  obsLitMask;
  int          obsLitCnt [4];
  int          obsBad;
  int          obsBusy;

  countdown_display #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) u_dut (
    .clock  (clock),
    .reset  (reset),
    .count  (count),
    .finish (finish),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // Cathode patterns for decimal digits, gfedcba, active-low.
  function automatic logic [6:0] refSeg(input int digit);
    logic [6:0] p;
    case (digit)
      0: p = 7'b1000000;
      1: p = 7'b1111001;
      2: p = 7'b0100100;
      3: p = 7'b0110000;
      4: p = 7'b0011001;
      5: p = 7'b0010010;
      6: p = 7'b0000010;
      7: p = 7'b1111000;
      8: p = 7'b0000000;
      9: p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Which digits should be lit for a timer value.
  function automatic logic [3:0] refLitMask(input int value);
    int sat;
    int pow;
    logic [3:0] m;
    sat = (value > 9999) ? 9999 : value;
    pow = 1;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i] = (i == 0) || (sat >= pow);
      pow = pow * 10;
    end
    return m;
  endfunction

  // Per-digit pattern (blank for unlit digits), digit i in bits [7i+6:7i].
  function automatic logic [27:0] refImage(input int value);
    int sat;
    int pow;
    logic [27:0] img;
    logic [3:0] m;
    sat = (value > 9999) ? 9999 : value;
    m = refLitMask(value);
    pow = 1;
    for (int i = 0; i < 4; i++) begin
      img[i*7 +: 7] = m[i] ? refSeg((sat / pow) % 10) : 7'b1111111;
      pow = pow * 10;
    end
    return img;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] c, input logic f);
    count  = c;
    finish = f;
  endtask

  // Advances one edge and counts how many samples busy stays high.
  task automatic runConversion(output int highCnt);
    int guard;
    tick();
    highCnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < BUSY_LIMIT) begin
      highCnt++;
      tick();
      guard++;
    end
  endtask

  // Samples n cycles and records what each digit position displayed.
  task automatic observeScan(input int n);
    int idx;
    obsImage   = {4{7'b1111111}};
    obsLitMask = '0;
    obsBad     = 0;
    obsBusy    = 0;
    for (int i = 0; i < 4; i++) obsLitCnt[i] = 0;
    repeat (n) begin
      tick();
      if (busy === 1'b1) obsBusy++;
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) begin
        if (obsLitCnt[idx] > 0 && seg !== obsImage[idx*7 +: 7]) obsBad++;
        obsImage[idx*7 +: 7] = seg;
        obsLitCnt[idx]++;
        obsLitMask[idx] = 1'b1;
      end else if (an !== 4'b1111) begin
        obsBad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(16'd0, 1'b0);
    tick();
    tick();
    checks++;
    if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
    checks++;
    if (seg !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_seg: got %b expected 1111111", seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int h;
    applyStimulus(16'd30, 1'b0);
    reset = 1'b0;
    runConversion(h);
    checks++;
    if (h !== 17) begin errors++; $display("[TB] FAIL basic_busy_len: got %0d expected 17", h); end
    observeScan(16);
    checks++;
    if (obsImage !== refImage(30)) begin errors++; $display("[TB] FAIL basic_image: got %h expected %h", obsImage, refImage(30)); end
    checks++;
    if (obsLitMask !== 4'b0011 || obsLitCnt[0] != 4 || obsLitCnt[1] != 4 || obsBad != 0) begin
      errors++;
      $display("[TB] FAIL basic_scan: mask %b units %0d tens %0d bad %0d expected mask 0011 4 4 0",
               obsLitMask, obsLitCnt[0], obsLitCnt[1], obsBad);
    end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("[TB] FAIL basic_dp: got %b expected 1", dp); end
  endtask

  task automatic test_saturate();
    int h;
    applyStimulus(16'd12345, 1'b0);
    runConversion(h);
    checks++;
    if (h !== 17) begin errors++; $display("[TB] FAIL sat_busy_len: got %0d expected 17", h); end
    observeScan(16);
    checks++;
    if (obsImage !== {4{7'b0010000}}) begin errors++; $display("[TB] FAIL sat_image: got %h expected %h", obsImage, {4{7'b0010000}}); end
    checks++;
    if (obsLitMask !== 4'b1111 || obsBad != 0) begin
      errors++;
      $display("[TB] FAIL sat_scan: mask %b bad %0d expected 1111 0", obsLitMask, obsBad);
    end
  endtask

  task automatic test_mid_change();
    int n;
    int guard;
    applyStimulus(16'd30, 1'b0);
    tick();
    n = 0;
    guard = 0;
    while (busy === 1'b1 && guard < BUSY_LIMIT) begin
      n++;
      if (n == 5) count = 16'd29;
      tick();
      guard++;
    end
    checks++;
    if (n !== 17) begin errors++; $display("[TB] FAIL mid_first_len: got %0d expected 17", n); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart: busy %b expected 1", busy); end
    observeScan(16);
    checks++;
    if (obsImage !== refImage(30)) begin errors++; $display("[TB] FAIL mid_first_image: got %h expected %h", obsImage, refImage(30)); end
    checks++;
    if (obsBusy !== 16) begin errors++; $display("[TB] FAIL mid_second_busy: got %0d expected 16", obsBusy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_second_end: busy %b expected 0", busy); end
    observeScan(16);
    checks++;
    if (obsImage !== refImage(29) || obsBad != 0) begin
      errors++;
      $display("[TB] FAIL mid_second_image: got %h bad %0d expected %h", obsImage, obsBad, refImage(29));
    end
  endtask

  task automatic test_blink();
    int h;
    int darkBad;
    int segBad;
    int litOn0;
    int litOn1;
    applyStimulus(16'd0, 1'b0);
    runConversion(h);
    checks++;
    if (h !== 17) begin errors++; $display("[TB] FAIL blink_setup_len: got %0d expected 17", h); end
    finish  = 1'b1;
    darkBad = 0;
    segBad  = 0;
    litOn0  = 0;
    litOn1  = 0;
    for (int j = 0; j < 56; j++) begin
      tick();
      if ((j >= 16 && j < 32) || j >= 48) begin
        if (an !== 4'b1111 || seg !== 7'b1111111) darkBad++;
      end else if (an === 4'b1110) begin
        if (seg !== 7'b1000000) segBad++;
        if (j < 16) litOn0++;
        else litOn1++;
      end else if (an !== 4'b1111) begin
        segBad++;
      end
    end
    checks++;
    if (darkBad !== 0) begin errors++; $display("[TB] FAIL blink_off_phase: %0d lit samples expected 0", darkBad); end
    checks++;
    if (segBad !== 0) begin errors++; $display("[TB] FAIL blink_on_image: %0d wrong samples expected 0", segBad); end
    checks++;
    if (litOn0 !== 4 || litOn1 !== 4) begin
      errors++;
      $display("[TB] FAIL blink_on_units: got %0d and %0d expected 4 and 4", litOn0, litOn1);
    end
    finish = 1'b0;
    tick();
    checks++;
    if (an !== 4'b1111) begin errors++; $display("[TB] FAIL blink_fall_delay: an %b expected 1111", an); end
    observeScan(16);
    checks++;
    if (obsImage !== refImage(0) || obsLitCnt[0] != 4 || obsBad != 0) begin
      errors++;
      $display("[TB] FAIL blink_fall_resume: got %h units %0d expected %h units 4", obsImage, obsLitCnt[0], refImage(0));
    end
  endtask

  task automatic test_reset_mid();
    int h;
    applyStimulus(16'd25, 1'b0);
    tick();
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: an %b seg %b dp %b busy %b expected 1111 1111111 1 0", an, seg, dp, busy);
    end
    tick();
    tick();
    reset = 1'b0;
    runConversion(h);
    checks++;
    if (h !== 17) begin errors++; $display("[TB] FAIL rstmid_busy_len: got %0d expected 17", h); end
    observeScan(16);
    checks++;
    if (obsImage !== refImage(25) || obsLitMask !== refLitMask(25) || obsBad != 0) begin
      errors++;
      $display("[TB] FAIL rstmid_image: got %h mask %b expected %h mask %b", obsImage, obsLitMask, refImage(25), refLitMask(25));
    end
  endtask

  task automatic test_sweep();
    int values [$];
    int prev;
    int v;
    int h;
    bit bad;
    values = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 65535};
    prev = 25;
    for (int k = 0; k < 60; k++) begin
      v = ((k % 8) == 7) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9999));
      values.push_back(v);
    end
    foreach (values[k]) begin
      v = values[k];
      if (v == prev) v = (v + 1) % 10000;
      prev = v;
      applyStimulus(16'(v), 1'b0);
      runConversion(h);
      observeScan(16);
      bad = (h != 17) || (obsImage !== refImage(v)) || (obsLitMask !== refLitMask(v)) || (obsBad != 0);
      for (int i = 0; i < 4; i++) begin
        if (obsLitCnt[i] != (refLitMask(v)[i] ? 4 : 0)) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("[TB] FAIL sweep_%0d: busy %0d image %h mask %b expected busy 17 image %h mask %b",
                 v, h, obsImage, obsLitMask, refImage(v), refLitMask(v));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_mid_change();
    test_blink();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
